ps2_hex_entry: RTL and testbench



---
 rtl/ps2_hex_entry_pkg.sv | 41 ++++
 rtl/ps2_hex_entry_if.sv | 24 ++
 rtl/ps2_frame_rx.sv | 133 +++++++++++++
 rtl/ps2_hex_entry.sv | 103 ++++++++++
 tb/tb_ps2_hex_entry.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/ps2_hex_entry_pkg.sv
// rtl/ps2_hex_entry_pkg.sv - shared scan codes, state encodings and nibble lookup
// Purpose: constants and types used by the frame receiver and the hex-entry decoder.
// Ports: none (package).
package ps2_hex_entry_pkg;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BKSP  = 8'h66;

  // Set-2 make codes for hex digits 0..F, indexed by nibble value.
  localparam logic [7:0] SC_DIGIT [16] = '{
    8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
    8'h3E, 8'h46, 8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B
  };

  typedef enum logic [1:0] {
    FR_IDLE,
    FR_DATA,
    FR_PARITY,
    FR_STOP
  } frame_state_t;

  typedef enum logic [1:0] {
    DEC_NORMAL,
    DEC_BREAK,
    DEC_EXT,
    DEC_EXT_BREAK
  } dec_state_t;

  // Returns {is_digit, nibble}; is_digit is 0 for any non-hex code.
  function automatic logic [4:0] hex_lookup(input logic [7:0] code);
    logic [4:0] res;
    res = 5'd0;
    for (int i = 0; i < 16; i++) begin
      if (code == SC_DIGIT[i]) res = {1'b1, 4'(i)};
    end
    return res;
  endfunction

endpackage

// File: rtl/ps2_hex_entry_if.sv
// rtl/ps2_hex_entry_if.sv - PS/2 line inputs and hex-entry result outputs
// Purpose: bundles the keyboard lines and the user-facing entry/submit signals.
// Ports: ps2_clk, ps2_data (keyboard -> design); user_value, value_valid,
//        entry_value, digit_count, frame_error (design -> consumer).
//        master = keyboard/consumer side, slave = ps2_hex_entry.
interface ps2_hex_entry_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] user_value;
  logic       value_valid;
  logic [7:0] entry_value;
  logic [1:0] digit_count;
  logic       frame_error;

  modport master (
    output ps2_clk, ps2_data,
    input  user_value, value_valid, entry_value, digit_count, frame_error
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output user_value, value_valid, entry_value, digit_count, frame_error
  );
endinterface

// File: rtl/ps2_frame_rx.sv
// rtl/ps2_frame_rx.sv - PS/2 frame receiver with input conditioning and timeout
// Purpose: synchronizes and filters the PS/2 lines, assembles 11-bit frames,
//          checks odd parity and stop bit, aborts stalled frames.
// Ports: clock, reset_n (async active-low); ps2_clk, ps2_data (raw async);
//        rx_byte (last received byte), byte_valid (1-cycle pulse),
//        frame_error (1-cycle pulse on parity/stop/timeout error).
module ps2_frame_rx
  import ps2_hex_entry_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_error
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          clk_filt;
  logic          clk_filt_d;
  logic [FW-1:0] filt_cnt;
  logic          fall;
  logic          data_bit;

  // Flops reset high so a bus already idle at release creates no edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync   <= 2'b11;
      data_sync  <= 2'b11;
      clk_filt   <= 1'b1;
      clk_filt_d <= 1'b1;
      filt_cnt   <= '0;
    end else begin
      clk_sync   <= {clk_sync[0], ps2_clk};
      data_sync  <= {data_sync[0], ps2_data};
      clk_filt_d <= clk_filt;
      // Accept a level change only after FILTER_LEN consecutive differing samples.
      if (clk_sync[1] == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        clk_filt <= clk_sync[1];
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
    end
  end

  assign fall     = clk_filt_d & ~clk_filt;
  assign data_bit = data_sync[1];

  frame_state_t state, state_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shift, shift_n;
  logic          parity_ok, parity_ok_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic          valid_n, err_n;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= FR_IDLE;
      bit_cnt     <= 3'd0;
      shift       <= 8'd0;
      parity_ok   <= 1'b0;
      tcnt        <= '0;
      byte_valid  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      state       <= state_n;
      bit_cnt     <= bit_cnt_n;
      shift       <= shift_n;
      parity_ok   <= parity_ok_n;
      tcnt        <= tcnt_n;
      byte_valid  <= valid_n;
      frame_error <= err_n;
    end
  end

  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    shift_n     = shift;
    parity_ok_n = parity_ok;
    valid_n     = 1'b0;
    err_n       = 1'b0;
    tcnt_n      = (state == FR_IDLE || fall) ? '0 : tcnt + TW'(1);
    case (state)
      FR_IDLE: begin
        if (fall && !data_bit) begin
          state_n   = FR_DATA;
          bit_cnt_n = 3'd0;
        end
      end
      FR_DATA: begin
        if (fall) begin
          shift_n   = {data_bit, shift[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = FR_PARITY;
        end
      end
      FR_PARITY: begin
        if (fall) begin
          parity_ok_n = ^{shift, data_bit};
          state_n     = FR_STOP;
        end
      end
      FR_STOP: begin
        if (fall) begin
          state_n = FR_IDLE;
          if (parity_ok && data_bit) valid_n = 1'b1;
          else                       err_n   = 1'b1;
        end
      end
      default: state_n = FR_IDLE;
    endcase
    if (state != FR_IDLE && !fall && tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
      err_n   = 1'b1;
      state_n = FR_IDLE;
    end
  end

  // The shift register holds the byte untouched until the next frame starts.
  assign rx_byte = shift;

endmodule

// File: rtl/ps2_hex_entry.sv
// rtl/ps2_hex_entry.sv - PS/2 hex-entry decoder producing the player's guess byte
// Purpose: decodes make/break/extended scan codes, assembles two hex digits,
//          submits the byte on Enter or keypad Enter.
// Ports: clock, reset_n (async active-low); bus (slave modport): ps2_clk/ps2_data in,
//        user_value, value_valid, entry_value, digit_count, frame_error out.
module ps2_hex_entry
  import ps2_hex_entry_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input logic           clock,
  input logic           reset_n,
  ps2_hex_entry_if.slave bus
);

  logic [7:0] rx_byte;
  logic       byte_valid;
  logic       frame_error;

  ps2_frame_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_frame_rx (
    .clock      (clock),
    .reset_n    (reset_n),
    .ps2_clk    (bus.ps2_clk),
    .ps2_data   (bus.ps2_data),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .frame_error(frame_error)
  );

  dec_state_t dec, dec_n;
  logic [7:0] user_value;
  logic       value_valid;
  logic [7:0] entry_value;
  logic [1:0] digit_count;
  logic [4:0] lookup;
  logic       digit_hit, bksp, submit;

  always_comb begin
    dec_n     = dec;
    digit_hit = 1'b0;
    bksp      = 1'b0;
    submit    = 1'b0;
    lookup    = hex_lookup(rx_byte);
    if (byte_valid) begin
      case (dec)
        DEC_NORMAL: begin
          if (rx_byte == SC_BREAK)      dec_n     = DEC_BREAK;
          else if (rx_byte == SC_EXT)   dec_n     = DEC_EXT;
          else if (lookup[4])           digit_hit = 1'b1;
          else if (rx_byte == SC_BKSP)  bksp      = 1'b1;
          else if (rx_byte == SC_ENTER) submit    = 1'b1;
        end
        DEC_EXT: begin
          if (rx_byte == SC_BREAK) begin
            dec_n = DEC_EXT_BREAK;
          end else begin
            dec_n  = DEC_NORMAL;
            submit = (rx_byte == SC_ENTER);
          end
        end
        // Release bytes are swallowed so key releases never act.
        default: dec_n = DEC_NORMAL;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dec         <= DEC_NORMAL;
      user_value  <= 8'd0;
      value_valid <= 1'b0;
      entry_value <= 8'd0;
      digit_count <= 2'd0;
    end else begin
      dec         <= dec_n;
      value_valid <= 1'b0;
      if (digit_hit) begin
        // Keep shifting past two digits so the last two typed are retained.
        entry_value <= {entry_value[3:0], lookup[3:0]};
        if (digit_count != 2'd2) digit_count <= digit_count + 2'd1;
      end else if (bksp) begin
        entry_value <= 8'd0;
        digit_count <= 2'd0;
      end else if (submit && digit_count != 2'd0) begin
        user_value  <= entry_value;
        value_valid <= 1'b1;
        entry_value <= 8'd0;
        digit_count <= 2'd0;
      end
    end
  end

  assign bus.user_value  = user_value;
  assign bus.value_valid = value_valid;
  assign bus.entry_value = entry_value;
  assign bus.digit_count = digit_count;
  assign bus.frame_error = frame_error;

endmodule

// File: tb/tb_ps2_hex_entry.sv
// tb/tb_ps2_hex_entry.sv - directed self-checking bench for ps2_hex_entry
module tb_ps2_hex_entry;

  localparam int HALF = 20;      // PS/2 half bit period in system clocks
  localparam int TMO  = 500;     // scaled-down timeout for simulation

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   vv_cnt = 0;
  int   fe_cnt = 0;
  int   long_cnt = 0;
  logic vv_prev = 1'b0;
  logic fe_prev = 1'b0;
  int   vv0, fe0;

  ps2_hex_entry_if bus ();

  ps2_hex_entry #(
    .FILTER_LEN    (8),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock  (clk),
    .reset_n(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (bus.value_valid) vv_cnt++;
    if (bus.frame_error) fe_cnt++;
    if ((bus.value_valid && vv_prev) || (bus.frame_error && fe_prev)) long_cnt++;
    vv_prev = bus.value_valid;
    fe_prev = bus.frame_error;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ps2_bit(input logic b);
    bus.ps2_data = b;
    cyc(HALF);
    bus.ps2_clk = 1'b0;
    cyc(HALF);
    bus.ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic bad_par);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit(bad_par ? ^d : ~^d);
    ps2_bit(1'b1);
    cyc(2 * HALF);
  endtask

  task automatic send_partial(input logic [7:0] d, input int nbits);
    ps2_bit(1'b0);
    for (int i = 0; i < nbits; i++) ps2_bit(d[i]);
  endtask

  task automatic key(input logic [7:0] code);
    send_frame(code, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(code, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.ps2_clk = 1'b1;
    bus.ps2_data = 1'b1;
    cyc(5);
    chk("rst_user", bus.user_value, 8'h00);
    chk("rst_entry", bus.entry_value, 8'h00);
    chk("rst_dc", bus.digit_count, 2'd0);
    chk("rst_vv", bus.value_valid, 1'b0);
    chk("rst_fe", bus.frame_error, 1'b0);
    rst_n = 1'b1;
    cyc(50);
    chk("rel_no_err", fe_cnt, 0);

    // 3, C, Enter
    send_frame(8'h26, 1'b0);
    chk("k3_entry", bus.entry_value, 8'h03);
    chk("k3_dc", bus.digit_count, 2'd1);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h26, 1'b0);
    chk("k3_rel_entry", bus.entry_value, 8'h03);
    send_frame(8'h21, 1'b0);
    chk("kc_entry", bus.entry_value, 8'h3C);
    chk("kc_dc", bus.digit_count, 2'd2);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h21, 1'b0);
    vv0 = vv_cnt;
    send_frame(8'h5A, 1'b0);
    chk("ent1_pulses", vv_cnt - vv0, 1);
    chk("ent1_user", bus.user_value, 8'h3C);
    chk("ent1_entry", bus.entry_value, 8'h00);
    chk("ent1_dc", bus.digit_count, 2'd0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h5A, 1'b0);
    chk("ent1_rel_pulses", vv_cnt - vv0, 1);

    // 1, 2, 5, Enter: third digit keeps last two
    key(8'h16);
    key(8'h1E);
    chk("k12_entry", bus.entry_value, 8'h12);
    key(8'h2E);
    chk("k125_entry", bus.entry_value, 8'h25);
    chk("k125_dc", bus.digit_count, 2'd2);
    vv0 = vv_cnt;
    key(8'h5A);
    chk("ent2_pulses", vv_cnt - vv0, 1);
    chk("ent2_user", bus.user_value, 8'h25);

    // A, Backspace, Enter with nothing typed
    key(8'h1C);
    chk("ka_entry", bus.entry_value, 8'h0A);
    key(8'h66);
    chk("bksp_entry", bus.entry_value, 8'h00);
    chk("bksp_dc", bus.digit_count, 2'd0);
    vv0 = vv_cnt;
    key(8'h5A);
    chk("empty_ent_pulses", vv_cnt - vv0, 0);
    chk("empty_ent_user", bus.user_value, 8'h25);

    // Bad parity on 45 with E pending
    key(8'h24);
    fe0 = fe_cnt;
    send_frame(8'h45, 1'b1);
    chk("par_err", fe_cnt - fe0, 1);
    chk("par_entry", bus.entry_value, 8'h0E);
    key(8'h66);

    // Abort after 4 data bits, then timeout, then key 7
    fe0 = fe_cnt;
    send_partial(8'h3D, 4);
    cyc(TMO + 100);
    chk("tmo_err", fe_cnt - fe0, 1);
    key(8'h3D);
    chk("k7_entry", bus.entry_value, 8'h07);
    chk("k7_dc", bus.digit_count, 2'd1);

    // F, F, keypad Enter, then its extended release
    key(8'h2B);
    key(8'h2B);
    chk("kff_entry", bus.entry_value, 8'hFF);
    vv0 = vv_cnt;
    send_frame(8'hE0, 1'b0);
    send_frame(8'h5A, 1'b0);
    chk("kpent_pulses", vv_cnt - vv0, 1);
    chk("kpent_user", bus.user_value, 8'hFF);
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h5A, 1'b0);
    chk("kpent_rel_pulses", vv_cnt - vv0, 1);
    chk("kpent_entry", bus.entry_value, 8'h00);

    // Reset mid-frame
    key(8'h46);
    chk("k9_entry", bus.entry_value, 8'h09);
    fe0 = fe_cnt;
    vv0 = vv_cnt;
    send_partial(8'h3E, 5);
    rst_n = 1'b0;
    cyc(5);
    chk("mid_rst_user", bus.user_value, 8'h00);
    chk("mid_rst_entry", bus.entry_value, 8'h00);
    chk("mid_rst_dc", bus.digit_count, 2'd0);
    rst_n = 1'b1;
    cyc(TMO + 200);
    chk("mid_rst_no_fe", fe_cnt - fe0, 0);
    chk("mid_rst_no_vv", vv_cnt - vv0, 0);
    key(8'h3E);
    chk("k8_entry", bus.entry_value, 8'h08);
    chk("k8_dc", bus.digit_count, 2'd1);
    chk("pulse_width", long_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
